// File: rtl/tuple_merge2.sv
// tuple_merge2: merges two partition streams into one.
// Per-input FIFOs feed a round-robin arbiter and one output register.

module tuple_merge2_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  input  logic [31:0]  tin,
  output logic         ready,
  output logic         nonempty,
  output logic [W-1:0] dout,
  output logic [31:0]  tout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [W-1:0]  mem_d [DEPTH];
  logic [31:0]   mem_t [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  // Ready comes from registered occupancy; held low during reset.
  assign ready    = ~reset & (occ < FULL);
  assign nonempty = (occ != '0);
  assign dout     = mem_d[rd_ptr];
  assign tout     = mem_t[rd_ptr];

  // Storage write; payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= din;
      mem_t[wr_ptr] <= tin;
    end
  end

  // Pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop)  rd_ptr <= rd_ptr + PONE;
      unique case ({push, pop})
        2'b10:   occ <= occ + ONE;
        2'b01:   occ <= occ - ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

module tuple_merge2 #(
  parameter int INPUT_SIZE = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  a_ready,
  input  logic [INPUT_SIZE-1:0] a_input,
  input  logic [31:0]           a_tag,
  input  logic                  a_valid,
  output logic                  b_ready,
  input  logic [INPUT_SIZE-1:0] b_input,
  input  logic [31:0]           b_tag,
  input  logic                  b_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] out,
  output logic [31:0]           out_tag,
  output logic                  out_src,
  output logic                  out_valid,
  output logic [31:0]           count_a,
  output logic [31:0]           count_b
);

  logic                  a_push;
  logic                  b_push;
  logic                  a_pop;
  logic                  b_pop;
  logic                  a_ne;
  logic                  b_ne;
  logic [INPUT_SIZE-1:0] a_head;
  logic [INPUT_SIZE-1:0] b_head;
  logic [31:0]           a_htag;
  logic [31:0]           b_htag;
  logic                  loadable;
  logic                  rr_ptr;

  assign a_push = a_valid & a_ready;
  assign b_push = b_valid & b_ready;

  tuple_merge2_fifo #(
    .W     (INPUT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fa (
    .clk      (clk),
    .reset    (reset),
    .push     (a_push),
    .pop      (a_pop),
    .din      (a_input),
    .tin      (a_tag),
    .ready    (a_ready),
    .nonempty (a_ne),
    .dout     (a_head),
    .tout     (a_htag)
  );

  tuple_merge2_fifo #(
    .W     (INPUT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fb (
    .clk      (clk),
    .reset    (reset),
    .push     (b_push),
    .pop      (b_pop),
    .din      (b_input),
    .tin      (b_tag),
    .ready    (b_ready),
    .nonempty (b_ne),
    .dout     (b_head),
    .tout     (b_htag)
  );

  // Arbiter: one pop per loadable edge, rr_ptr breaks ties.
  always_comb begin
    loadable = ~out_valid | out_ready;
    a_pop    = 1'b0;
    b_pop    = 1'b0;
    if (loadable) begin
      unique case ({a_ne, b_ne})
        2'b10:   a_pop = 1'b1;
        2'b01:   b_pop = 1'b1;
        2'b11: begin
          a_pop = ~rr_ptr;
          b_pop = rr_ptr;
        end
        default: ;
      endcase
    end
  end

  // Output register loads the popped head or drains when nothing is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_tag   <= '0;
      out_src   <= 1'b0;
      out_valid <= 1'b0;
    end else if (loadable) begin
      if (a_pop) begin
        out       <= a_head;
        out_tag   <= a_htag;
        out_src   <= 1'b0;
        out_valid <= 1'b1;
      end else if (b_pop) begin
        out       <= b_head;
        out_tag   <= b_htag;
        out_src   <= 1'b1;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer points at the side not served last.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (a_pop) begin
      rr_ptr <= 1'b1;
    end else if (b_pop) begin
      rr_ptr <= 1'b0;
    end
  end

  // Delivery counters, bumped on each output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_a <= '0;
      count_b <= '0;
    end else if (out_valid & out_ready) begin
      if (out_src) count_b <= count_b + 32'd1;
      else         count_a <= count_a + 32'd1;
    end
  end

endmodule
